// File: rtl/multicycle_chunk_adder_if.sv
// Bus bundle for the multi-cycle chunk adder: request side (start, operands,
// mode) and result side (busy/done handshake, sum and status flags).
interface multicycle_chunk_adder_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carryin;
    logic             subtract;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carryout;
    logic             overflow;
    logic             zero;

    modport master (
        output start, a, b, carryin, subtract,
        input  busy, done, sum, carryout, overflow, zero
    );

    modport slave (
        input  start, a, b, carryin, subtract,
        output busy, done, sum, carryout, overflow, zero
    );
endinterface

// File: rtl/multicycle_chunk_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands are summed CHUNK bits per
// clock through a narrow adder, with the carry rippled between chunks in a
// register. Operand registers shift right one chunk per cycle so the adder
// always sees the low chunk; the sum register fills from the top so the
// first chunk lands at bit 0 after the last step. WIDTH must be a multiple
// of CHUNK.
module multicycle_chunk_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_chunk_adder_if.slave bus
);
    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [CHUNK:0]   chunk_res;
    logic             accept;
    logic             last;

    // One chunk of the ripple: {carry, sum} of two CHUNK-bit slices plus carry.
    function automatic logic [CHUNK:0] chunk_add(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             cin);
        return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
    endfunction

    // Carry that entered the MSB position, recovered from the MSB sum bit.
    function automatic logic msb_carry_in(input logic x_msb,
                                          input logic y_msb,
                                          input logic s_msb);
        return x_msb ^ y_msb ^ s_msb;
    endfunction

    // Next-state, chunk datapath and flag logic.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        zero_d    = zero_q;
        idx_d     = idx_q;
        chunk_res = chunk_add(a_q[CHUNK-1:0], b_q[CHUNK-1:0], carry_q);
        accept    = bus.start && (state_q != RUN);
        last      = (idx_q == IDXW'(N - 1));

        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    // Subtraction is a + ~b + 1; carryin only matters for add.
                    a_d     = bus.a;
                    b_d     = bus.subtract ? ~bus.b : bus.b;
                    carry_d = bus.subtract ? 1'b1 : bus.carryin;
                    idx_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    zero_d  = 1'b0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                carry_d = chunk_res[CHUNK];
                sum_d   = (sum_q >> CHUNK) |
                          (WIDTH'(chunk_res[CHUNK-1:0]) << (WIDTH - CHUNK));
                idx_d   = idx_q + 1'b1;
                if (last) begin
                    cout_d  = chunk_res[CHUNK];
                    ovf_d   = msb_carry_in(a_q[CHUNK-1], b_q[CHUNK-1],
                                           chunk_res[CHUNK-1]) ^ chunk_res[CHUNK];
                    zero_d  = (sum_d == '0);
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control, result and flag registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    // Operand shift registers; contents are don't-care outside RUN.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign bus.busy     = (state_q == RUN);
    assign bus.done     = (state_q == DONE);
    assign bus.sum      = sum_q;
    assign bus.carryout = cout_q;
    assign bus.overflow = ovf_q;
    assign bus.zero     = zero_q;
endmodule

// File: tb/tb_multicycle_chunk_adder.sv
// Directed bench for multicycle_chunk_adder: a 32/8 instance driven from a
// vector table plus handshake/reset sequences, and a 16/16 single-chunk instance.
module tb_multicycle_chunk_adder;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    multicycle_chunk_adder_if #(.WIDTH(32)) bus32 ();
    multicycle_chunk_adder_if #(.WIDTH(16)) bus16 ();

    multicycle_chunk_adder #(.WIDTH(32), .CHUNK(8)) dut32 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus32)
    );

    multicycle_chunk_adder #(.WIDTH(16), .CHUNK(16)) dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Issue one op on the 32-bit DUT; lat counts edges from accept edge to done.
    task automatic op32(input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub, output int lat);
        @(negedge clk);
        bus32.start = 1'b1; bus32.a = a; bus32.b = b;
        bus32.carryin = cin; bus32.subtract = sub;
        @(negedge clk);
        bus32.start = 1'b0;
        lat = 0;
        chk("busy_after_accept", {63'd0, bus32.busy}, 64'd1);
        while (!bus32.done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub, output int lat);
        @(negedge clk);
        bus16.start = 1'b1; bus16.a = a; bus16.b = b;
        bus16.carryin = cin; bus16.subtract = sub;
        @(negedge clk);
        bus16.start = 1'b0;
        lat = 0;
        while (!bus16.done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int pulses;
        int first_e;
        int second_e;
        logic [31:0] first_s;
        logic [31:0] second_s;
        int seen;

        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        bus32.start = 1'b0; bus32.a = '0; bus32.b = '0; bus32.carryin = 1'b0; bus32.subtract = 1'b0;
        bus16.start = 1'b0; bus16.a = '0; bus16.b = '0; bus16.carryin = 1'b0; bus16.subtract = 1'b0;

        vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0, 32'h9999_9999, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{32'h0000_000A, 32'h0000_000A, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
        vecs[9] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'd0, bus32.busy}, 64'd0);
        chk("rst_done", {63'd0, bus32.done}, 64'd0);
        chk("rst_sum", {32'd0, bus32.sum}, 64'd0);
        chk("rst_flags", {61'd0, bus32.carryout, bus32.overflow, bus32.zero}, 64'd0);
        chk("rst16_sum", {48'd0, bus16.sum}, 64'd0);
        reset = 1'b0;

        // Table-driven vectors on the 32/8 instance
        for (int i = 0; i < 10; i++) begin
            op32(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, lat);
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'd4);
            chk($sformatf("v%0d_sum", i), {32'd0, bus32.sum}, {32'd0, vecs[i].sum});
            chk($sformatf("v%0d_cout", i), {63'd0, bus32.carryout}, {63'd0, vecs[i].cout});
            chk($sformatf("v%0d_ovf", i), {63'd0, bus32.overflow}, {63'd0, vecs[i].ovf});
            chk($sformatf("v%0d_zero", i), {63'd0, bus32.zero}, {63'd0, vecs[i].zero});
            @(negedge clk);
            chk($sformatf("v%0d_done_one_cycle", i), {63'd0, bus32.done}, 64'd0);
            chk($sformatf("v%0d_result_held", i), {32'd0, bus32.sum}, {32'd0, vecs[i].sum});
        end

        // Reset in the middle of RUN
        @(negedge clk);
        bus32.start = 1'b1; bus32.a = 32'h0101_0101; bus32.b = 32'h0000_0000;
        bus32.carryin = 1'b0; bus32.subtract = 1'b0;
        @(negedge clk);
        bus32.start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_busy", {63'd0, bus32.busy}, 64'd0);
        chk("midrst_done", {63'd0, bus32.done}, 64'd0);
        chk("midrst_sum", {32'd0, bus32.sum}, 64'd0);
        chk("midrst_flags", {61'd0, bus32.carryout, bus32.overflow, bus32.zero}, 64'd0);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus32.done || bus32.busy) seen++;
        end
        chk("midrst_no_done", 64'(seen), 64'd0);

        // start held high: back-to-back ops, operands changed mid-RUN
        pulses = 0; first_e = -1; second_e = -1; first_s = '0; second_s = '0;
        @(negedge clk);
        bus32.start = 1'b1; bus32.a = 32'd3; bus32.b = 32'd4;
        bus32.carryin = 1'b0; bus32.subtract = 1'b0;
        for (int e = 0; e < 10; e++) begin
            @(negedge clk);
            if (e == 0) begin
                bus32.a = 32'd10;
                bus32.b = 32'd20;
            end
            if (e == 5) chk("b2b_busy_no_gap", {63'd0, bus32.busy}, 64'd1);
            if (bus32.done) begin
                pulses++;
                if (pulses == 1) begin first_e = e; first_s = bus32.sum; end
                if (pulses == 2) begin second_e = e; second_s = bus32.sum; end
            end
        end
        bus32.start = 1'b0;
        chk("b2b_pulses", 64'(pulses), 64'd2);
        chk("b2b_first_edge", 64'(first_e), 64'd4);
        chk("b2b_second_edge", 64'(second_e), 64'd9);
        chk("b2b_first_sum", {32'd0, first_s}, 64'd7);
        chk("b2b_second_sum", {32'd0, second_s}, 64'd30);
        @(negedge clk);
        chk("b2b_idle_done", {63'd0, bus32.done}, 64'd0);
        chk("b2b_idle_busy", {63'd0, bus32.busy}, 64'd0);

        // start pulse while busy is ignored
        @(negedge clk);
        bus32.start = 1'b1; bus32.a = 32'd100; bus32.b = 32'd1;
        bus32.carryin = 1'b0; bus32.subtract = 1'b0;
        @(negedge clk);
        bus32.start = 1'b0;
        @(negedge clk);
        bus32.start = 1'b1; bus32.a = 32'd5; bus32.b = 32'd5; bus32.subtract = 1'b1;
        @(negedge clk);
        bus32.start = 1'b0;
        lat = 2;
        while (!bus32.done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("busy_start_latency", 64'(lat), 64'd4);
        chk("busy_start_sum", {32'd0, bus32.sum}, 64'd101);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus32.done || bus32.busy) seen++;
        end
        chk("busy_start_no_extra_op", 64'(seen), 64'd0);

        // Single-chunk instance
        op16(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
        chk("w16_latency", 64'(lat), 64'd1);
        chk("w16_sum", {48'd0, bus16.sum}, 64'h8000);
        chk("w16_ovf", {63'd0, bus16.overflow}, 64'd1);
        chk("w16_cout", {63'd0, bus16.carryout}, 64'd0);
        chk("w16_zero", {63'd0, bus16.zero}, 64'd0);
        op16(16'h0003, 16'h0005, 1'b1, 1'b1, lat);
        chk("w16_sub_latency", 64'(lat), 64'd1);
        chk("w16_sub_sum", {48'd0, bus16.sum}, 64'hFFFE);
        chk("w16_sub_cout", {63'd0, bus16.carryout}, 64'd0);
        op16(16'hFFFF, 16'h0000, 1'b1, 1'b0, lat);
        chk("w16_wrap_sum", {48'd0, bus16.sum}, 64'h0);
        chk("w16_wrap_flags", {61'd0, bus16.carryout, bus16.overflow, bus16.zero}, 64'b101);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
